// File: rtl/partition_resp_checker_pkg.sv
// rtl/partition_resp_checker_pkg.sv - shared state enum and response-metric helpers
package partition_resp_checker_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] popcount(input logic [FN_W-1:0] v);
    logic [FN_W-1:0] c;
    c = '0;
    for (int i = 0; i < FN_W; i++) c = c + FN_W'(v[i]);
    return c;
  endfunction

  // Operands are zero-extended unsigned values narrower than FN_W, so the
  // wide subtraction never overflows and the magnitude fits the operand width.
  function automatic logic [FN_W-1:0] abs_diff(input logic [FN_W-1:0] a,
                                               input logic [FN_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/partition_resp_checker_acc.sv
// rtl/partition_resp_checker_acc.sv - mismatch, Hamming-sum and worst-error accumulators
module resp_metric_acc
  import partition_resp_checker_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int N_OUT = 4,
  parameter int HD_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic [N_OUT-1:0]  po_exact,
  input  logic [N_OUT-1:0]  po_approx,
  output logic [N_IN:0]     err_count,
  output logic [HD_W-1:0]   hd_sum,
  output logic [N_OUT-1:0]  max_abs_err
);

  logic [N_OUT-1:0] diff_mag;
  logic [HD_W-1:0]  diff_bits;

  assign diff_mag  = N_OUT'(abs_diff(FN_W'(po_approx), FN_W'(po_exact)));
  assign diff_bits = HD_W'(popcount(FN_W'(po_approx ^ po_exact)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count   <= '0;
      hd_sum      <= '0;
      max_abs_err <= '0;
    end else if (clear) begin
      err_count   <= '0;
      hd_sum      <= '0;
      max_abs_err <= '0;
    end else if (sample) begin
      if (po_approx != po_exact) err_count <= err_count + (N_IN+1)'(1);
      hd_sum <= hd_sum + diff_bits;
      if (diff_mag > max_abs_err) max_abs_err <= diff_mag;
    end
  end

endmodule

// File: rtl/partition_resp_checker.sv
// rtl/partition_resp_checker.sv - exhaustive pattern sweep with exact/approx response scoring
module partition_resp_checker
  import partition_resp_checker_pkg::*;
#(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1,
  localparam int HD_W  = N_IN + $clog2(N_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_OUT-1:0]  po_exact,
  input  logic [N_OUT-1:0]  po_approx,
  output logic [N_IN-1:0]   pi_out,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     err_count,
  output logic [HD_W-1:0]   hd_sum,
  output logic [N_OUT-1:0]  max_abs_err
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   pi_nxt;
  logic [SC_W-1:0]   settle_cnt, settle_nxt;
  logic              busy_nxt, done_nxt;
  logic              acc_clear, acc_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pi_out     <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pi_out     <= pi_nxt;
      settle_cnt <= settle_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pi_nxt     = pi_out;
    settle_nxt = settle_cnt;
    busy_nxt   = busy;
    done_nxt   = done;
    acc_clear  = 1'b0;
    acc_sample = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_clear  = 1'b1;
          pi_nxt     = '0;
          settle_nxt = '0;
          busy_nxt   = 1'b1;
          done_nxt   = 1'b0;
          state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SC_W'(SETTLE - 1)) state_nxt = S_SAMPLE;
        else settle_nxt = settle_cnt + SC_W'(1);
      end
      S_SAMPLE: begin
        acc_sample = 1'b1;
        // The last pattern stays on pi_out so the final response remains observable.
        if (&pi_out) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          pi_nxt     = pi_out + N_IN'(1);
          settle_nxt = '0;
          state_nxt  = S_SETTLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  resp_metric_acc #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .HD_W  (HD_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .sample      (acc_sample),
    .po_exact    (po_exact),
    .po_approx   (po_approx),
    .err_count   (err_count),
    .hd_sum      (hd_sum),
    .max_abs_err (max_abs_err)
  );

endmodule

// File: tb/tb_partition_resp_checker.sv
// tb/tb_partition_resp_checker.sv - self-checking bench for partition_resp_checker
module tb_partition_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, start3;
  logic [3:0] exact_tab [128];
  logic [3:0] approx_tab [128];

  logic [6:0] pi_out, pi3;
  logic [3:0] po_exact, po_approx, po3_ex, po3_ap;
  logic       busy, done, busy3, done3;
  logic [7:0] err_count, err3;
  logic [9:0] hd_sum, hd3;
  logic [3:0] max_abs_err, max3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign po_exact  = exact_tab[pi_out];
  assign po_approx = approx_tab[pi_out];

  // Partition with one cycle of output latency for the SETTLE=3 build.
  always @(posedge clk) begin
    po3_ex <= exact_tab[pi3];
    po3_ap <= approx_tab[pi3];
  end

  partition_resp_checker #(.N_IN(7), .N_OUT(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .po_exact(po_exact), .po_approx(po_approx),
    .pi_out(pi_out), .busy(busy), .done(done), .err_count(err_count),
    .hd_sum(hd_sum), .max_abs_err(max_abs_err)
  );

  partition_resp_checker #(.N_IN(7), .N_OUT(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .po_exact(po3_ex), .po_approx(po3_ap),
    .pi_out(pi3), .busy(busy3), .done(done3), .err_count(err3),
    .hd_sum(hd3), .max_abs_err(max3)
  );

  typedef struct {
    int mode;
    int exp_err;   // negative: take expectations from the reference model
    int exp_hd;
    int exp_max;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill_tables(input int mode);
    for (int p = 0; p < 128; p++) begin
      int lo, hi, mx, r;
      lo = p % 16;
      hi = p / 16;
      mx = (lo > hi) ? lo : hi;
      r  = int'($urandom);
      case (mode)
        0: begin exact_tab[p] = 4'(mx); approx_tab[p] = 4'(mx); end
        1: begin exact_tab[p] = 4'(mx); approx_tab[p] = 4'(mx) & 4'hE; end
        2: begin exact_tab[p] = 4'h0;   approx_tab[p] = 4'hF; end
        3: begin exact_tab[p] = 4'($urandom); approx_tab[p] = 4'($urandom); end
        default: begin
          exact_tab[p]  = 4'(r);
          approx_tab[p] = 4'(r) ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
      endcase
    end
  endtask

  task automatic model(output int e, output int h, output int m);
    e = 0; h = 0; m = 0;
    for (int p = 0; p < 128; p++) begin
      int d;
      d = int'(approx_tab[p]) - int'(exact_tab[p]);
      if (d < 0) d = -d;
      if (approx_tab[p] != exact_tab[p]) e++;
      h += $countones(approx_tab[p] ^ exact_tab[p]);
      if (d > m) m = d;
    end
  endtask

  // Pulses start; cyc counts clocks from the accepting edge until done is seen.
  task automatic run1(input int restart_at, input bit chk_clear, output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (chk_clear) begin
      check("clear.err", err_count, 0);
      check("clear.hd", hd_sum, 0);
      check("clear.max", max_abs_err, 0);
      check("clear.busy", busy, 1);
      check("clear.done", done, 0);
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input int cyc, input int e, input int h, input int m);
    check({tag, ".cycles"}, cyc, 256);
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".pi_out"}, pi_out, 127);
    check({tag, ".err"}, err_count, e);
    check({tag, ".hd"}, hd_sum, h);
    check({tag, ".max"}, max_abs_err, m);
  endtask

  initial begin
    int cyc, e, h, m;
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{1, 68, 68, 1};
    vecs[2] = '{2, 128, 512, 15};
    vecs[3] = '{3, -1, -1, -1};
    vecs[4] = '{4, -1, -1, -1};
    fill_tables(0);

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pi_out", pi_out, 0);
    check("rst.err", err_count, 0);
    check("rst.hd", hd_sum, 0);
    check("rst.max", max_abs_err, 0);
    check("rst.busy3", busy3, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fill_tables(vecs[i].mode);
      model(e, h, m);
      if (vecs[i].exp_err >= 0) begin
        e = vecs[i].exp_err; h = vecs[i].exp_hd; m = vecs[i].exp_max;
      end
      run1(0, 1'b0, cyc);
      check_sweep($sformatf("vec%0d", i), cyc, e, h, m);
    end

    // start while busy is ignored; start after done restarts from cleared results.
    fill_tables(2);
    run1(50, 1'b0, cyc);
    check_sweep("busy_start", cyc, 128, 512, 15);
    run1(0, 1'b1, cyc);
    check_sweep("restart", cyc, 128, 512, 15);

    // Reset mid-sweep discards partial results.
    fill_tables(3);
    model(e, h, m);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.pi_out", pi_out, 0);
    check("midrst.err", err_count, 0);
    check("midrst.hd", hd_sum, 0);
    check("midrst.max", max_abs_err, 0);
    @(negedge clk); rst = 1'b0;
    run1(0, 1'b0, cyc);
    check_sweep("after_rst", cyc, e, h, m);

    // SETTLE=3 build against a one-cycle-latency partition.
    fill_tables(4);
    model(e, h, m);
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s3.cycles", cyc, 512);
    check("s3.done", done3, 1);
    check("s3.busy", busy3, 0);
    check("s3.pi_out", pi3, 127);
    check("s3.err", err3, e);
    check("s3.hd", hd3, h);
    check("s3.max", max3, m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
